wt_cache_mem_responder: RTL
===========================

WT_CACHE_MEM_RESPONDER -- requirements
Module: wt_cache_mem_responder

Interface
REQ-001 SHALL have parameter MemWords, default 1024, giving backing-store depth in 64-bit words (power of two).
REQ-002 SHALL have parameter Latency, default 2, giving acceptance-to-return delay in cycles (>=1).
REQ-003 SHALL have parameter TidWidth, default 2, giving the transaction-ID width.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 icache_data_req_i  input  1  I$ fill request, held until acked.
REQ-007 icache_data_ack_o  output  1  single-cycle I$ request acceptance.
REQ-008 icache_paddr_i  input  64  I$ fill address; bits [3:0] ignored.
REQ-009 icache_tid_i  input  TidWidth  I$ transaction ID.
REQ-010 icache_rtrn_vld_o  output  1  I$ return valid, no backpressure.
REQ-011 icache_rtrn_data_o  output  128  I$ returned line.
REQ-012 icache_rtrn_tid_o  output  TidWidth  I$ returned ID.
REQ-013 dcache_data_req_i  input  1  D$ request, held until acked.
REQ-014 dcache_data_ack_o  output  1  single-cycle D$ request acceptance.
REQ-015 dcache_rtype_i  input  1  0 = load (line read), 1 = store (word write).
REQ-016 dcache_paddr_i  input  64  D$ address; load ignores [3:0], store ignores [2:0].
REQ-017 dcache_wdata_i  input  64  store data.
REQ-018 dcache_be_i  input  8  store byte enables.
REQ-019 dcache_tid_i  input  TidWidth  D$ transaction ID.
REQ-020 dcache_rtrn_vld_o  output  1  D$ return valid, no backpressure.
REQ-021 dcache_rtrn_type_o  output  1  0 = load data, 1 = store ack.
REQ-022 dcache_rtrn_data_o  output  128  D$ returned line (zero for store ack).
REQ-023 dcache_rtrn_tid_o  output  TidWidth  D$ returned ID.

Function
REQ-024 SHALL accept at most one request per cycle, via combinational ack = req AND grant in the same cycle.
REQ-025 SHALL grant the sole requester when only one port requests.
REQ-026 SHALL, when both ports request, grant the port not granted last; the last-granted register updates only on a grant.
REQ-027 SHALL index memory words by paddr[log2(MemWords)+2:3]; higher address bits wrap (are ignored).
REQ-028 SHALL form a line read from word pair {word[idx|1], word[idx&~1]}, with the lower address in bits [63:0].
REQ-029 SHALL commit a store's enabled bytes at the acceptance clock edge; disabled bytes are unchanged.
REQ-030 SHALL sample load/fill data at the acceptance edge, after any store accepted in an earlier cycle (program order).
REQ-031 SHALL, for a request accepted in cycle N, assert the matching rtrn_vld for exactly one cycle in cycle N+Latency, with the accepted TID.
REQ-032 SHALL return store acks with dcache_rtrn_type_o=1 and data zero; loads return type 0.
REQ-033 SHALL keep return payloads zero whenever the corresponding rtrn_vld is low.
REQ-034 SHALL deliver returns in acceptance order; I$ and D$ returns never coincide, since at most one acceptance occurs per cycle.
REQ-035 SHALL keep ack low while req is low; req dropping without ack is legal and discards the request.

Reset
REQ-036 SHALL drive all outputs to 0 during reset; the last-granted register resets to D$ so I$ wins the first contention.
REQ-037 SHALL clear all in-flight pipeline entries on reset; no return appears for requests accepted before reset.
REQ-038 SHALL leave backing-store contents unreset (undefined until written).

Structure
REQ-039 SHALL place the return-type encoding (load/store-ack) and line-width constant in wt_cache_pkg.
REQ-040 SHALL use one sub-module, wt_mem_resp_pipe: a Latency-deep valid/port/type/TID/data delay line with asynchronous reset.
REQ-041 SHALL be synthesizable without vendor macros; the memory is a plain register/array inference.

Verification
REQ-042 Store paddr 0x40, data 0x1122334455667788, be 0xFF, tid 1 -> dcache_data_ack_o same cycle; store ack (type 1, tid 1) 2 cycles later.
REQ-043 After REQ-042, I$ fill paddr 0x48, tid 2 -> icache_rtrn_data_o[63:0]=0x1122334455667788, tid 2, 2 cycles after ack.
REQ-044 Store be=0x0F, data 0xAAAAAAAABBBBBBBB at 0x40, then D$ load 0x40 -> data[63:0]=0x11223344BBBBBBBB.
REQ-045 Both ports request continuously for 6 cycles after reset -> acks alternate I$, D$, I$, D$, I$, D$.
REQ-046 Assert rst_ni low one cycle after an accept -> no rtrn_vld on either port afterwards.
REQ-047 Store at paddr 0x40 + MemWords*8 -> D$ load of 0x40 returns the same data (wrap).

Source files
------------

// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared encodings and widths for the write-through cache memory responder
package wt_cache_pkg;

    localparam int LineWidth = 128;
    localparam int WordWidth = 64;

    typedef enum logic {
        RTRN_LOAD      = 1'b0,
        RTRN_STORE_ACK = 1'b1
    } rtrn_type_e;

    typedef enum logic {
        PORT_ICACHE = 1'b0,
        PORT_DCACHE = 1'b1
    } port_e;

endpackage

// File: rtl/wt_cache_mem_responder_if.sv
// wt_cache_mem_responder_if: I$ fill and D$ load/store request/return channels
interface wt_cache_mem_responder_if #(
    parameter int TidWidth = 2
) ();
    import wt_cache_pkg::*;

    logic                 icache_data_req_i;
    logic                 icache_data_ack_o;
    logic [63:0]          icache_paddr_i;
    logic [TidWidth-1:0]  icache_tid_i;
    logic                 icache_rtrn_vld_o;
    logic [LineWidth-1:0] icache_rtrn_data_o;
    logic [TidWidth-1:0]  icache_rtrn_tid_o;

    logic                 dcache_data_req_i;
    logic                 dcache_data_ack_o;
    logic                 dcache_rtype_i;
    logic [63:0]          dcache_paddr_i;
    logic [63:0]          dcache_wdata_i;
    logic [7:0]           dcache_be_i;
    logic [TidWidth-1:0]  dcache_tid_i;
    logic                 dcache_rtrn_vld_o;
    logic                 dcache_rtrn_type_o;
    logic [LineWidth-1:0] dcache_rtrn_data_o;
    logic [TidWidth-1:0]  dcache_rtrn_tid_o;

    modport master (
        output icache_data_req_i, icache_paddr_i, icache_tid_i,
        input  icache_data_ack_o, icache_rtrn_vld_o, icache_rtrn_data_o, icache_rtrn_tid_o,
        output dcache_data_req_i, dcache_rtype_i, dcache_paddr_i, dcache_wdata_i,
        output dcache_be_i, dcache_tid_i,
        input  dcache_data_ack_o, dcache_rtrn_vld_o, dcache_rtrn_type_o,
        input  dcache_rtrn_data_o, dcache_rtrn_tid_o
    );

    modport slave (
        input  icache_data_req_i, icache_paddr_i, icache_tid_i,
        output icache_data_ack_o, icache_rtrn_vld_o, icache_rtrn_data_o, icache_rtrn_tid_o,
        input  dcache_data_req_i, dcache_rtype_i, dcache_paddr_i, dcache_wdata_i,
        input  dcache_be_i, dcache_tid_i,
        output dcache_data_ack_o, dcache_rtrn_vld_o, dcache_rtrn_type_o,
        output dcache_rtrn_data_o, dcache_rtrn_tid_o
    );

endinterface

// File: rtl/wt_mem_resp_pipe.sv
// wt_mem_resp_pipe: Latency-deep delay line carrying accepted responses to the return ports
module wt_mem_resp_pipe
    import wt_cache_pkg::*;
#(
    parameter int Latency  = 2,
    parameter int TidWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 vld_i,
    input  port_e                port_i,
    input  rtrn_type_e           type_i,
    input  logic [TidWidth-1:0]  tid_i,
    input  logic [LineWidth-1:0] data_i,
    output logic                 vld_o,
    output port_e                port_o,
    output rtrn_type_e           type_o,
    output logic [TidWidth-1:0]  tid_o,
    output logic [LineWidth-1:0] data_o
);

    logic [Latency-1:0]                vld_q;
    logic [Latency-1:0]                port_q;
    logic [Latency-1:0]                type_q;
    logic [Latency-1:0][TidWidth-1:0]  tid_q;
    logic [Latency-1:0][LineWidth-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            port_q <= '0;
            type_q <= '0;
            tid_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            port_q[0] <= port_i;
            type_q[0] <= type_i;
            tid_q[0]  <= tid_i;
            data_q[0] <= data_i;
            for (int i = 1; i < Latency; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
                type_q[i] <= type_q[i-1];
                tid_q[i]  <= tid_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[Latency-1];
    assign port_o = port_e'(port_q[Latency-1]);
    assign type_o = rtrn_type_e'(type_q[Latency-1]);
    assign tid_o  = tid_q[Latency-1];
    assign data_o = data_q[Latency-1];

endmodule

// File: rtl/wt_cache_mem_responder.sv
// wt_cache_mem_responder: arbitrated I$/D$ backing store with fixed-latency in-order returns
module wt_cache_mem_responder
    import wt_cache_pkg::*;
#(
    parameter int MemWords = 1024,
    parameter int Latency  = 2,
    parameter int TidWidth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    wt_cache_mem_responder_if.slave  bus
);

    localparam int AddrBits = $clog2(MemWords);

    logic [WordWidth-1:0] mem_q [MemWords];
    port_e                last_q, last_d;
    logic                 ack_i, ack_d, store;
    logic [AddrBits-1:0]  i_idx, d_idx, rd_idx;
    logic [LineWidth-1:0] rd_line;
    logic                 p_vld, i_vld, d_vld;
    port_e                p_port;
    rtrn_type_e           p_type;
    logic [TidWidth-1:0]  p_tid;
    logic [LineWidth-1:0] p_data;
    logic                 unused_paddr;

    // Contention goes to whichever port was not granted last; reset favours I$.
    assign ack_i  = rst_ni && bus.icache_data_req_i &&
                    (!bus.dcache_data_req_i || last_q == PORT_DCACHE);
    assign ack_d  = rst_ni && bus.dcache_data_req_i && !ack_i;
    assign last_d = ack_i ? PORT_ICACHE : ack_d ? PORT_DCACHE : last_q;
    assign store  = ack_d && bus.dcache_rtype_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= PORT_DCACHE;
        else         last_q <= last_d;
    end

    assign i_idx   = bus.icache_paddr_i[AddrBits+2:3];
    assign d_idx   = bus.dcache_paddr_i[AddrBits+2:3];
    assign rd_idx  = ack_i ? i_idx : d_idx;
    assign rd_line = {mem_q[rd_idx | AddrBits'(1)], mem_q[rd_idx & ~AddrBits'(1)]};

    always_ff @(posedge clk_i) begin
        if (store) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.dcache_be_i[b]) mem_q[d_idx][8*b +: 8] <= bus.dcache_wdata_i[8*b +: 8];
            end
        end
    end

    wt_mem_resp_pipe #(
        .Latency  (Latency),
        .TidWidth (TidWidth)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (ack_i || ack_d),
        .port_i (ack_i ? PORT_ICACHE : PORT_DCACHE),
        .type_i (store ? RTRN_STORE_ACK : RTRN_LOAD),
        .tid_i  (ack_i ? bus.icache_tid_i : bus.dcache_tid_i),
        .data_i ((ack_i || (ack_d && !store)) ? rd_line : '0),
        .vld_o  (p_vld),
        .port_o (p_port),
        .type_o (p_type),
        .tid_o  (p_tid),
        .data_o (p_data)
    );

    assign i_vld = p_vld && p_port == PORT_ICACHE;
    assign d_vld = p_vld && p_port == PORT_DCACHE;

    assign bus.icache_data_ack_o  = ack_i;
    assign bus.icache_rtrn_vld_o  = i_vld;
    assign bus.icache_rtrn_data_o = i_vld ? p_data : '0;
    assign bus.icache_rtrn_tid_o  = i_vld ? p_tid : '0;
    assign bus.dcache_data_ack_o  = ack_d;
    assign bus.dcache_rtrn_vld_o  = d_vld;
    assign bus.dcache_rtrn_type_o = d_vld ? p_type : RTRN_LOAD;
    assign bus.dcache_rtrn_data_o = d_vld ? p_data : '0;
    assign bus.dcache_rtrn_tid_o  = d_vld ? p_tid : '0;

    // Upper address bits wrap and the byte offset is irrelevant to word access.
    assign unused_paddr = ^{bus.icache_paddr_i[63:AddrBits+3], bus.icache_paddr_i[2:0],
                            bus.dcache_paddr_i[63:AddrBits+3], bus.dcache_paddr_i[2:0]};

endmodule
